// File: rtl/stage_phase_accumulator_pkg.sv
// Shared types and slot-ID helpers for the phase accumulator stage.
// A slot ID packs {voice, operator}; voice is the upper field.
package stage_phase_accumulator_pkg;

  localparam int unsigned NUM_VOICES    = 32;
  localparam int unsigned NUM_OPERATORS = 8;
  localparam int unsigned ACC_WIDTH     = 24;
  localparam int unsigned PHASE_WIDTH   = 16;
  localparam int unsigned VOICE_BITS    = $clog2(NUM_VOICES);
  localparam int unsigned OP_BITS       = $clog2(NUM_OPERATORS);
  localparam int unsigned SLOT_BITS     = VOICE_BITS + OP_BITS;
  localparam int unsigned NUM_SLOTS     = NUM_VOICES * NUM_OPERATORS;

  typedef logic [VOICE_BITS-1:0]  VoiceID_t;
  typedef logic [OP_BITS-1:0]     OperatorID_t;
  typedef logic [SLOT_BITS-1:0]   VoiceOperatorID_t;
  typedef logic [PHASE_WIDTH-1:0] PhaseStep_t;
  typedef logic [ACC_WIDTH-1:0]   PhaseAcc_t;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } acc_state_e;

  function automatic VoiceOperatorID_t makeVoiceOperatorID(input VoiceID_t voice,
                                                           input OperatorID_t op);
    return {voice, op};
  endfunction

  function automatic VoiceID_t getVoiceID(input VoiceOperatorID_t id);
    return id[SLOT_BITS-1 -: VOICE_BITS];
  endfunction

  function automatic OperatorID_t getOperatorID(input VoiceOperatorID_t id);
    return id[OP_BITS-1:0];
  endfunction

endpackage

// File: rtl/stage_phase_accumulator_voice_operator_ram.sv
// One-write/one-read synchronous RAM with one entry per voice/operator slot.
// A read and a write to the same address in one cycle returns the old data.
module voice_operator_ram
  import stage_phase_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  VoiceOperatorID_t waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  VoiceOperatorID_t raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [NUM_SLOTS];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stage_phase_accumulator.sv
// Pipeline head: sweeps every voice/operator slot, advancing a 24-bit phase
// accumulator per slot and emitting its upper 16 bits two cycles later.
module stage_phase_accumulator
  import stage_phase_accumulator_pkg::*;
(
  input  logic             i_Clock,
  input  logic             i_Reset,
  output logic [15:0]      o_Phase,
  output logic             o_NoteOn,
  output VoiceOperatorID_t o_VoiceOperator,
  output logic             o_Valid,
  output logic             o_ConfigReady,
  input  logic             i_PhaseStepWriteEnable,
  input  logic             i_NoteOnWriteEnable,
  input  VoiceOperatorID_t i_ConfigWriteAddr,
  input  logic [15:0]      i_ConfigWriteData
);

  acc_state_e              state_q;
  VoiceOperatorID_t        sweep_q, seq_q, s1_slot_q, vo_q;
  logic                    s1_valid_q, s1_noteon_q, s1_pend_q;
  logic [NUM_VOICES-1:0]   noteon_q, noteon_d;
  logic [NUM_SLOTS-1:0]    pend_q, pend_d;
  logic [PHASE_WIDTH-1:0]  phase_q;
  logic                    noteon_out_q, valid_q, ready_q;

  PhaseAcc_t               acc_rd, acc_wdata;
  PhaseStep_t              step_rd, step_wdata;
  VoiceOperatorID_t        acc_waddr, step_waddr;
  logic                    acc_we, step_we, run;
  VoiceID_t                cfg_voice;

  assign run       = (state_q == ST_RUN);
  assign cfg_voice = getVoiceID(i_ConfigWriteAddr);

  voice_operator_ram #(.WIDTH(ACC_WIDTH)) u_acc_ram (
    .clk_i   (i_Clock),
    .we_i    (acc_we),
    .waddr_i (acc_waddr),
    .wdata_i (acc_wdata),
    .raddr_i (seq_q),
    .rdata_o (acc_rd)
  );

  voice_operator_ram #(.WIDTH(PHASE_WIDTH)) u_step_ram (
    .clk_i   (i_Clock),
    .we_i    (step_we),
    .waddr_i (step_waddr),
    .wdata_i (step_wdata),
    .raddr_i (seq_q),
    .rdata_o (step_rd)
  );

  // CLEAR owns both RAM write ports; in RUN the accumulator port carries the
  // stage-2 write-back and the step port carries config writes.
  always_comb begin
    acc_we     = 1'b1;
    acc_waddr  = sweep_q;
    acc_wdata  = '0;
    step_we    = 1'b1;
    step_waddr = sweep_q;
    step_wdata = '0;
    if (run) begin
      acc_we     = s1_valid_q;
      acc_waddr  = s1_slot_q;
      acc_wdata  = s1_pend_q ? PhaseAcc_t'(step_rd) : acc_rd + PhaseAcc_t'(step_rd);
      step_we    = i_PhaseStepWriteEnable;
      step_waddr = i_ConfigWriteAddr;
      step_wdata = i_ConfigWriteData;
    end
  end

  // Pending bit of the slot being read is consumed; a simultaneous set wins.
  always_comb begin
    noteon_d = noteon_q;
    pend_d   = pend_q;
    if (run) begin
      pend_d[seq_q] = 1'b0;
      if (i_NoteOnWriteEnable) begin
        noteon_d[cfg_voice] = i_ConfigWriteData[0];
        if (i_ConfigWriteData[0] && !noteon_q[cfg_voice]) begin
          for (int unsigned op = 0; op < NUM_OPERATORS; op++) begin
            pend_d[makeVoiceOperatorID(cfg_voice, OperatorID_t'(op))] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q      <= ST_CLEAR;
      sweep_q      <= '0;
      seq_q        <= '0;
      noteon_q     <= '0;
      pend_q       <= '0;
      s1_valid_q   <= 1'b0;
      s1_slot_q    <= '0;
      s1_noteon_q  <= 1'b0;
      s1_pend_q    <= 1'b0;
      phase_q      <= '0;
      noteon_out_q <= 1'b0;
      vo_q         <= '0;
      valid_q      <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      noteon_q    <= noteon_d;
      pend_q      <= pend_d;
      s1_valid_q  <= run;
      s1_slot_q   <= seq_q;
      s1_noteon_q <= noteon_q[getVoiceID(seq_q)];
      s1_pend_q   <= pend_q[seq_q];
      valid_q     <= s1_valid_q;
      if (s1_valid_q) begin
        phase_q      <= s1_pend_q ? '0 : acc_rd[ACC_WIDTH-1 -: PHASE_WIDTH];
        noteon_out_q <= s1_noteon_q;
        vo_q         <= s1_slot_q;
      end
      case (state_q)
        ST_CLEAR: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == VoiceOperatorID_t'(NUM_SLOTS - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN:   seq_q   <= seq_q + 1'b1;
        default:  state_q <= ST_CLEAR;
      endcase
    end
  end

  assign o_Phase         = phase_q;
  assign o_NoteOn        = noteon_out_q;
  assign o_VoiceOperator = vo_q;
  assign o_Valid         = valid_q;
  assign o_ConfigReady   = ready_q;

endmodule

// File: tb/tb_stage_phase_accumulator.sv
// Scoreboard bench for stage_phase_accumulator: per-slot expected visits are
// queued by the stimulus and consumed by a monitor on every valid output.
module tb_stage_phase_accumulator;
  import stage_phase_accumulator_pkg::*;

  logic             clk = 1'b0;
  logic             i_Reset;
  logic [15:0]      o_Phase;
  logic             o_NoteOn;
  VoiceOperatorID_t o_VoiceOperator;
  logic             o_Valid;
  logic             o_ConfigReady;
  logic             i_PhaseStepWriteEnable;
  logic             i_NoteOnWriteEnable;
  VoiceOperatorID_t i_ConfigWriteAddr;
  logic [15:0]      i_ConfigWriteData;

  always #5 clk = ~clk;

  stage_phase_accumulator dut (
    .i_Clock                (clk),
    .i_Reset                (i_Reset),
    .o_Phase                (o_Phase),
    .o_NoteOn               (o_NoteOn),
    .o_VoiceOperator        (o_VoiceOperator),
    .o_Valid                (o_Valid),
    .o_ConfigReady          (o_ConfigReady),
    .i_PhaseStepWriteEnable (i_PhaseStepWriteEnable),
    .i_NoteOnWriteEnable    (i_NoteOnWriteEnable),
    .i_ConfigWriteAddr      (i_ConfigWriteAddr),
    .i_ConfigWriteData      (i_ConfigWriteData)
  );

  typedef struct {
    int          slot;
    logic [15:0] phase;
    logic        noteon;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Voice-3 slot histories for revolutions 2..10 (index 0 = revolution 2).
  logic [15:0] ph24 [9] = '{16'h0, 16'h3, 16'h0, 16'h3, 16'h6, 16'h9, 16'hC, 16'h0, 16'h3};
  logic [15:0] ph26 [9] = '{16'h0, 16'h12, 16'h0, 16'h12, 16'h24, 16'h36, 16'h0, 16'h12, 16'h24};
  logic [15:0] ph27 [9] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h2, 16'h4};
  logic [15:0] ph9  [5] = '{16'h0, 16'h80, 16'h100, 16'h180, 16'h1C0};
  logic [8:0]  no24 = 9'b110111100;
  logic [8:0]  noV3 = 9'b111111100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int slot, input logic [15:0] ph, input logic no);
    exp_t e;
    e.slot   = slot;
    e.phase  = ph;
    e.noteon = no;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int slot);
    bit hit = 1'b0;
    for (int n = 0; n < 600 && !hit; n++) begin
      tick();
      hit = o_Valid && (o_VoiceOperator == VoiceOperatorID_t'(slot));
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_slot%0d: slot not emitted within 600 cycles", slot);
    end
  endtask

  task automatic cfg_write(input int addr, input logic [15:0] data, input bit step, input bit note);
    i_ConfigWriteAddr      = VoiceOperatorID_t'(addr);
    i_ConfigWriteData      = data;
    i_PhaseStepWriteEnable = step;
    i_NoteOnWriteEnable    = note;
    tick();
    i_PhaseStepWriteEnable = 1'b0;
    i_NoteOnWriteEnable    = 1'b0;
  endtask

  task automatic do_reset();
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    check("rst_valid", o_Valid, 0);
    check("rst_ready", o_ConfigReady, 0);
    check("rst_phase", o_Phase, 0);
    check("rst_noteon", o_NoteOn, 0);
    check("rst_slot", o_VoiceOperator, 0);
  endtask

  // Starts on the first sample after a reset edge; optional config write at cycle write_at.
  task automatic clear_check(input int write_at);
    int low = 0;
    bit bad = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (o_ConfigReady) break;
      low++;
      if (o_Valid || o_NoteOn) bad = 1'b1;
      i_PhaseStepWriteEnable = (i == write_at);
      i_NoteOnWriteEnable    = (i == write_at);
      tick();
    end
    i_PhaseStepWriteEnable = 1'b0;
    i_NoteOnWriteEnable    = 1'b0;
    check("clear_len", low, 256);
    check("clear_quiet", bad, 0);
    check("valid_lat0", o_Valid, 0);
    tick();
    check("valid_lat1", o_Valid, 0);
    tick();
    check("valid_first", o_Valid, 1);
    check("first_slot", o_VoiceOperator, 0);
  endtask

  task automatic drain(input int limit);
    for (int n = 0; n < limit && exp_q.size() != 0; n++) tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected visits never emitted, first slot %0d",
               exp_q.size(), exp_q[0].slot);
    end
  endtask

  // Monitor: sequencing and scoreboard comparison.
  initial begin
    int prev_slot = 0;
    bit prev_valid = 1'b0;
    forever begin
      tick();
      if (o_Valid) begin
        if (prev_valid) check("seq_order", o_VoiceOperator, (prev_slot + 1) % 256);
        for (int i = 0; i < exp_q.size(); i++) begin
          if (exp_q[i].slot == int'(o_VoiceOperator)) begin
            check($sformatf("slot%0d_phase", exp_q[i].slot), o_Phase, exp_q[i].phase);
            check($sformatf("slot%0d_noteon", exp_q[i].slot), o_NoteOn, exp_q[i].noteon);
            exp_q.delete(i);
            break;
          end
        end
      end
      prev_valid = o_Valid;
      prev_slot  = int'(o_VoiceOperator);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    i_Reset                = 1'b1;
    i_PhaseStepWriteEnable = 1'b0;
    i_NoteOnWriteEnable    = 1'b0;
    i_ConfigWriteAddr      = '0;
    i_ConfigWriteData      = '0;

    // Power-up clear, then one revolution of zero phases.
    do_reset();
    for (int s = 0; s < 256; s++) push(s, 16'h0, 1'b0);
    clear_check(-1);

    // Revolution 2: program steps while slots 0..4 are emitted.
    wait_out(0);
    for (int r = 0; r < 4; r++) push(5, 16'(r), 1'b0);
    for (int r = 0; r < 2; r++) push(6, 16'h0, 1'b0);
    for (int r = 0; r < 5; r++) push(9, ph9[r], 1'b0);
    // step 0xFFFF: visit n shows ((n*0xFFFF) mod 2^24) >> 8
    for (int n = 0; n < 256; n++) push(10, 16'((n * 32'hFFFF) >> 8), 1'b0);
    push(10, 16'hFFFF, 1'b0);
    push(10, 16'h00FE, 1'b0);
    for (int r = 0; r < 9; r++) begin
      push(23, 16'h0, 1'b0);
      push(24, ph24[r], no24[r]);
      push(25, 16'h0, noV3[r]);
      push(26, ph26[r], noV3[r]);
      push(27, ph27[r], noV3[r]);
      push(28, 16'h0, noV3[r]);
    end
    cfg_write(5, 16'h0100, 1'b1, 1'b0);
    cfg_write(9, 16'h8000, 1'b1, 1'b0);
    cfg_write(10, 16'hFFFF, 1'b1, 1'b0);
    cfg_write(24, 16'h0300, 1'b1, 1'b0);
    cfg_write(26, 16'h1234, 1'b1, 1'b0);

    wait_out(0); wait_out(100);
    cfg_write(26, 16'h0001, 1'b0, 1'b1);   // voice 3 rising: restart all 8 slots
    wait_out(0); wait_out(7);
    cfg_write(9, 16'h4000, 1'b1, 1'b0);    // slot 9 read at this edge keeps old step
    wait_out(0); wait_out(100);
    cfg_write(26, 16'h0001, 1'b0, 1'b1);   // already on: no restart
    wait_out(0); wait_out(0); wait_out(100);
    cfg_write(26, 16'h0000, 1'b0, 1'b1);   // note off
    wait_out(0); wait_out(22);
    cfg_write(27, 16'h0201, 1'b1, 1'b1);   // note-on edge while slot 24 is read
    drain(70000);

    // Reset mid-RUN, then again 100 cycles into CLEAR; writes during CLEAR dropped.
    do_reset();
    begin
      bit bad = 1'b0;
      i_ConfigWriteAddr = VoiceOperatorID_t'(5);
      i_ConfigWriteData = 16'h0101;
      for (int i = 0; i < 100; i++) begin
        if (o_ConfigReady || o_Valid) bad = 1'b1;
        i_PhaseStepWriteEnable = (i == 50);
        i_NoteOnWriteEnable    = (i == 50);
        tick();
      end
      i_PhaseStepWriteEnable = 1'b0;
      i_NoteOnWriteEnable    = 1'b0;
      check("partial_clear_quiet", bad, 0);
    end
    do_reset();
    for (int s = 0; s < 256; s++) push(s, 16'h0, 1'b0);
    push(5, 16'h0, 1'b0);
    push(5, 16'h0, 1'b0);
    push(0, 16'h0, 1'b0);
    push(10, 16'h0, 1'b0);
    push(26, 16'h0, 1'b0);
    clear_check(30);
    drain(1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
